assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, CPU address width.
REQ-002 SHALL have parameter WORD_W, default 64, CPU data word width.
REQ-003 SHALL have parameter SET_BITS, default 1, log2 of set count; ways fixed at 2.
REQ-004 SHALL have parameter WORD_BITS, default 1, log2 of words per block; block width BLK_W = WORD_W<<WORD_BITS.
REQ-005 SHALL have parameter BYTE_BITS, default 2, ignored low address bits; TAG_W = ADDR_W-SET_BITS-WORD_BITS-BYTE_BITS.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset. One clock; reset is synchronous and active-low.
REQ-007 SHALL have ports: cpu_req in 1 request valid; cpu_we in 1 write(1)/read(0); cpu_addr in ADDR_W; cpu_wdata in WORD_W.
REQ-008 SHALL have ports: cpu_ready out 1 idle, can accept; cpu_done out 1 one-cycle completion pulse; cpu_rdata out WORD_W; cpu_hit out 1 hit flag for the completing access.
REQ-009 SHALL have ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W block-aligned; mem_wdata out BLK_W; mem_ack in 1; mem_rdata in BLK_W.

Function
REQ-010 SHALL split cpu_addr as {tag, set, word, byte}, byte bits ignored.
REQ-011 SHALL hold per line: valid, dirty, TAG_W tag, BLK_W data; per set one LRU bit naming the way to replace.
REQ-012 SHALL use FSM IDLE, LOOKUP, WB, FILL, DONE; request accepted only when cpu_req && cpu_ready (cpu_ready=1 only in IDLE); address/data/we latched on accept.
REQ-013 LOOKUP: hit if a valid way's tag matches; hit -> DONE; miss with victim dirty -> WB; miss with victim clean/invalid -> FILL.
REQ-014 Victim SHALL be the first invalid way (way 0 before way 1), else the way named by LRU.
REQ-015 WB: mem_req=1, mem_we=1, mem_addr={victim tag, set, zeros}, mem_wdata=victim data, held stable until mem_ack; on mem_ack -> FILL.
REQ-016 FILL: mem_req=1, mem_we=0, mem_addr={tag, set, zeros}; on mem_ack install mem_rdata, valid=1, dirty=0, tag -> DONE.
REQ-017 DONE: read returns selected word on cpu_rdata; write merges cpu_wdata into selected word, dirty=1; LRU set to other way; cpu_done=1 one cycle -> IDLE.
REQ-018 Word 0 SHALL occupy block MSBs (word i at bits BLK_W-1-i*WORD_W downto BLK_W-(i+1)*WORD_W).
REQ-019 Latency: hit completes (cpu_done) 2 cycles after accept; miss adds mem wait cycles per transaction.
REQ-020 cpu_rdata SHALL hold its value until the next read completes; writes do not alter it.
REQ-021 mem_ack outside WB/FILL SHALL be ignored; cpu_req while busy SHALL be ignored (not queued).

Reset
REQ-022 On clk edge with rst_n=0: FSM -> IDLE, all valid/dirty/LRU = 0, cpu_done=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; data arrays not cleared.
REQ-023 Reset mid-WB/FILL SHALL abandon the transaction at once; dirty data is lost, no partial install.

Configuration
REQ-024 With CACHE_STATS_EN defined: outputs hit_cnt and miss_cnt (32 bits each), incremented at LOOKUP, saturating at all-ones, cleared by reset.
REQ-025 Without CACHE_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-026 Package cache_pkg SHALL hold the FSM state enum and the line-struct/width helper constants derived from parameters.
REQ-027 Tag compare and victim select SHALL be sub-module cache_tag_cmp (inputs: both ways' valid/tag/LRU, lookup tag; outputs: hit, hit_way, victim_way).

Verification
REQ-028 Reset, read 0x000 with mem_rdata=0x1111..._2222... ack after 3 cycles -> cpu_hit=0, cpu_rdata=0x1111_1111_1111_1111, one FILL, no WB.
REQ-029 Re-read 0x004 -> cpu_hit=1, cpu_done 2 cycles after accept, cpu_rdata=0x2222_2222_2222_2222, no mem_req.
REQ-030 Write 0xDEAD to 0x000 (hit), then miss 0x100 and 0x200 same set -> WB at mem_addr 0x000 with word0=0xDEAD, then FILL 0x200.
REQ-031 Alternate reads 0x000/0x100 then 0x200 -> victim is LRU way (not most recent), verified by subsequent hit/miss.
REQ-032 Assert rst_n during FILL wait -> mem_req=0 next cycle, cpu_ready=1, following read of same address misses.
REQ-033 With CACHE_STATS_EN, after REQ-028..030 sequence -> hit_cnt and miss_cnt equal bench-counted values.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared FSM encoding and geometry helpers for the 2-way set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  localparam int unsigned WAYS = 2;

  function automatic int tag_width(input int addr_w, input int set_bits,
                                   input int word_bits, input int byte_bits);
    return addr_w - set_bits - word_bits - byte_bits;
  endfunction

  function automatic int blk_width(input int word_w, input int word_bits);
    return word_w << word_bits;
  endfunction

endpackage

// File: rtl/cache_tag_cmp.sv
// Two-way tag compare and victim selection (first invalid way, else LRU way).
module cache_tag_cmp #(
  parameter int TAG_W = 6
) (
  input  logic             valid0,
  input  logic             valid1,
  input  logic [TAG_W-1:0] tag0,
  input  logic [TAG_W-1:0] tag1,
  input  logic             lru,
  input  logic [TAG_W-1:0] tag,
  output logic             hit,
  output logic             hit_way,
  output logic             victim_way
);

  logic match0, match1;

  always_comb begin
    match0     = valid0 && (tag0 == tag);
    match1     = valid1 && (tag1 == tag);
    hit        = match0 || match1;
    hit_way    = !match0;
    victim_way = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
  end

endmodule

// File: rtl/assoc_cache.sv
// 2-way set-associative write-back cache with per-set LRU and block memory port.
// Optional CACHE_STATS_EN adds saturating hit/miss counters.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int WORD_W    = 64,
  parameter int SET_BITS  = 1,
  parameter int WORD_BITS = 1,
  parameter int BYTE_BITS = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cpu_req,
  input  logic                                   cpu_we,
  input  logic [ADDR_W-1:0]                      cpu_addr,
  input  logic [WORD_W-1:0]                      cpu_wdata,
  output logic                                   cpu_ready,
  output logic                                   cpu_done,
  output logic [WORD_W-1:0]                      cpu_rdata,
  output logic                                   cpu_hit,
  output logic                                   mem_req,
  output logic                                   mem_we,
  output logic [ADDR_W-1:0]                      mem_addr,
  output logic [blk_width(WORD_W, WORD_BITS)-1:0] mem_wdata,
  input  logic                                   mem_ack,
  input  logic [blk_width(WORD_W, WORD_BITS)-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt
`endif
);

  localparam int TAG_W = tag_width(ADDR_W, SET_BITS, WORD_BITS, BYTE_BITS);
  localparam int BLK_W = blk_width(WORD_W, WORD_BITS);
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int OFF_W = WORD_BITS + BYTE_BITS;

  state_t state, state_nx;

  logic [SETS-1:0]  valid [WAYS];
  logic [SETS-1:0]  dirty [WAYS];
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tags  [WAYS][SETS];
  logic [BLK_W-1:0] data  [WAYS][SETS];

  logic                 req_we;
  logic [TAG_W-1:0]     req_tag;
  logic [SET_BITS-1:0]  req_set;
  logic [WORD_BITS-1:0] req_word;
  logic [WORD_W-1:0]    req_wdata;
  logic                 act_way;
  logic                 hit_r;

  logic             hit, hit_way, victim_way;
  logic             victim_dirty;
  logic [BLK_W-1:0] cur_blk;
  logic [WORD_W-1:0] rd_word;
  int unsigned      word_ofs;
  logic             unused_byte_bits;

  assign unused_byte_bits = ^cpu_addr[BYTE_BITS-1:0];

  cache_tag_cmp #(.TAG_W(TAG_W)) u_tag_cmp (
    .valid0     (valid[0][req_set]),
    .valid1     (valid[1][req_set]),
    .tag0       (tags[0][req_set]),
    .tag1       (tags[1][req_set]),
    .lru        (lru[req_set]),
    .tag        (req_tag),
    .hit        (hit),
    .hit_way    (hit_way),
    .victim_way (victim_way)
  );

  always_comb begin
    victim_dirty = valid[victim_way][req_set] && dirty[victim_way][req_set];
    cur_blk      = data[act_way][req_set];
    // Word 0 lives in the block MSBs, so the offset counts down from the top.
    word_ofs     = (unsigned'(WORDS) - 1 - 32'(req_word)) * unsigned'(WORD_W);
    rd_word      = cur_blk[word_ofs +: WORD_W];
    cpu_ready    = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nx = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)               state_nx = S_DONE;
        else if (victim_dirty) state_nx = S_WB;
        else                   state_nx = S_FILL;
      end
      S_WB:     if (mem_ack) state_nx = S_FILL;
      S_FILL:   if (mem_ack) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid[0]  <= '0;
      valid[1]  <= '0;
      dirty[0]  <= '0;
      dirty[1]  <= '0;
      lru       <= '0;
      cpu_done  <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_set   <= '0;
      req_word  <= '0;
      req_wdata <= '0;
      act_way   <= 1'b0;
      hit_r     <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
            req_set   <= cpu_addr[OFF_W +: SET_BITS];
            req_word  <= cpu_addr[BYTE_BITS +: WORD_BITS];
            req_wdata <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          hit_r   <= hit;
          act_way <= hit ? hit_way : victim_way;
          if (!hit) begin
            mem_req <= 1'b1;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {tags[victim_way][req_set], req_set, {OFF_W{1'b0}}};
              mem_wdata <= data[victim_way][req_set];
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_set, {OFF_W{1'b0}}};
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_set, {OFF_W{1'b0}}};
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            mem_req                 <= 1'b0;
            valid[act_way][req_set] <= 1'b1;
            dirty[act_way][req_set] <= 1'b0;
          end
        end
        S_DONE: begin
          cpu_done     <= 1'b1;
          cpu_hit      <= hit_r;
          lru[req_set] <= ~act_way;
          if (req_we) dirty[act_way][req_set] <= 1'b1;
          else        cpu_rdata <= rd_word;
        end
        default: ;
      endcase
    end
  end

  // Arrays are not reset; gating on rst_n keeps an aborted fill from installing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_FILL && mem_ack) begin
        tags[act_way][req_set] <= req_tag;
        data[act_way][req_set] <= mem_rdata;
      end else if (state == S_DONE && req_we) begin
        data[act_way][req_set][word_ofs +: WORD_W] <= req_wdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 32'd1;
      else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: expected hit/rdata queued per request, checked at cpu_done.
module tb_assoc_cache;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 64;
  localparam int BLK_W  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [WORD_W-1:0] cpu_wdata = '0;
  logic              cpu_ready, cpu_done, cpu_hit;
  logic [WORD_W-1:0] cpu_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic              mem_ack = 1'b0;
  logic [BLK_W-1:0]  mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  assoc_cache #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SET_BITS(1), .WORD_BITS(1), .BYTE_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    logic        hit;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          bench_hits = 0;
  int          bench_misses = 0;
  logic [63:0] last_rd = '0;

  logic [BLK_W-1:0] mem [128];
  int unsigned      wait_cnt = 0;
  int               wb_cnt = 0;
  int               fill_cnt = 0;
  logic [9:0]       last_wb_addr = '0;
  logic [9:0]       last_fill_addr = '0;
  logic [127:0]     last_wb_data = '0;

  function automatic logic [63:0] w0(input logic [6:0] b);
    return {8'hA0, 48'h0, 1'b0, b};
  endfunction

  function automatic logic [63:0] w1(input logic [6:0] b);
    return {8'hB0, 48'h0, 1'b0, b};
  endfunction

  // Block memory: acks 3 cycles after it first sees a request.
  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      wait_cnt++;
      if (wait_cnt >= 3) begin
        if (mem_we) begin
          mem[mem_addr[9:3]] = mem_wdata;
          wb_cnt++;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr[9:3]];
          fill_cnt++;
          last_fill_addr = mem_addr;
        end
        mem_ack = 1'b1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic access(input logic we, input logic [9:0] addr, input logic [63:0] wd,
                        input logic exp_hit, input logic [63:0] exp_rd, output int lat);
    exp_t e;
    int   guard = 0;
    lat = -1;
    while (!cpu_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (!cpu_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout addr=%h got=%b want=1", addr, cpu_ready);
      return;
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    e.hit = exp_hit; e.rdata = exp_rd;
    sb.push_back(e);
    if (exp_hit) bench_hits++; else bench_misses++;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    lat = 0;
    while (!cpu_done && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    if (!cpu_done) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout addr=%h got=%b want=1", addr, cpu_done);
      return;
    end
    n_cmp++;
    if (cpu_hit !== e.hit) begin
      n_err++;
      $display("FAIL hit addr=%h got=%b want=%b", addr, cpu_hit, e.hit);
    end
    n_cmp++;
    if (cpu_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL rdata addr=%h got=%h want=%h", addr, cpu_rdata, e.rdata);
    end
  endtask

  task automatic rd(input logic [9:0] addr, input logic exp_hit, input logic [63:0] exp_rd,
                    output int lat);
    access(1'b0, addr, '0, exp_hit, exp_rd, lat);
    last_rd = exp_rd;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [63:0] wd, input logic exp_hit,
                    output int lat);
    access(1'b1, addr, wd, exp_hit, last_rd, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b want=1", cpu_ready); end
    n_cmp++; if (cpu_done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b want=0", cpu_done); end
    n_cmp++; if (cpu_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit got=%b want=0", cpu_hit); end
    n_cmp++; if (cpu_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata got=%h want=0", cpu_rdata); end
    n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_ctl got=%b%b want=00", mem_req, mem_we); end
    n_cmp++; if (mem_addr !== 10'h0) begin n_err++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    n_cmp++; if (mem_wdata !== 128'h0) begin n_err++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    rst_n = 1'b1;
    bench_hits = 0;
    bench_misses = 0;
  endtask

  task automatic test_read_miss();
    int lat, f0, b0;
    f0 = fill_cnt; b0 = wb_cnt;
    rd(10'h000, 1'b0, 64'h1111_1111_1111_1111, lat);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL miss_latency got=%0d want=5", lat); end
    n_cmp++; if (fill_cnt - f0 !== 1) begin n_err++; $display("FAIL miss_fills got=%0d want=1", fill_cnt - f0); end
    n_cmp++; if (wb_cnt - b0 !== 0) begin n_err++; $display("FAIL miss_wbs got=%0d want=0", wb_cnt - b0); end
    n_cmp++; if (last_fill_addr !== 10'h000) begin n_err++; $display("FAIL miss_fill_addr got=%h want=000", last_fill_addr); end
  endtask

  task automatic test_read_hit();
    int lat, f0, b0;
    f0 = fill_cnt; b0 = wb_cnt;
    rd(10'h004, 1'b1, 64'h2222_2222_2222_2222, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency got=%0d want=2", lat); end
    n_cmp++; if ((fill_cnt - f0) + (wb_cnt - b0) !== 0) begin n_err++; $display("FAIL hit_mem_txns got=%0d want=0", (fill_cnt - f0) + (wb_cnt - b0)); end
  endtask

  task automatic test_write_wb();
    int lat, f0, b0;
    f0 = fill_cnt; b0 = wb_cnt;
    wr(10'h000, 64'hDEAD, 1'b1, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wr_hit_latency got=%0d want=2", lat); end
    rd(10'h100, 1'b0, w0(7'h20), lat);
    rd(10'h200, 1'b0, w0(7'h40), lat);
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL wb_fill_latency got=%0d want=9", lat); end
    n_cmp++; if (wb_cnt - b0 !== 1) begin n_err++; $display("FAIL wb_count got=%0d want=1", wb_cnt - b0); end
    n_cmp++; if (last_wb_addr !== 10'h000) begin n_err++; $display("FAIL wb_addr got=%h want=000", last_wb_addr); end
    n_cmp++;
    if (last_wb_data !== {64'hDEAD, 64'h2222_2222_2222_2222}) begin
      n_err++; $display("FAIL wb_data got=%h want=%h", last_wb_data, {64'hDEAD, 64'h2222_2222_2222_2222});
    end
    n_cmp++; if (fill_cnt - f0 !== 2) begin n_err++; $display("FAIL wb_fills got=%0d want=2", fill_cnt - f0); end
    n_cmp++; if (last_fill_addr !== 10'h200) begin n_err++; $display("FAIL wb_fill_addr got=%h want=200", last_fill_addr); end
`ifdef CACHE_STATS_EN
    n_cmp++; if (hit_cnt !== 32'(bench_hits)) begin n_err++; $display("FAIL stat_hits got=%0d want=%0d", hit_cnt, bench_hits); end
    n_cmp++; if (miss_cnt !== 32'(bench_misses)) begin n_err++; $display("FAIL stat_misses got=%0d want=%0d", miss_cnt, bench_misses); end
`endif
  endtask

  task automatic test_lru();
    logic [9:0]  addrs [8] = '{10'h000, 10'h100, 10'h000, 10'h100, 10'h000, 10'h200, 10'h000, 10'h100};
    logic        hits  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] datas [8];
    int lat, b0;
    datas = '{64'hDEAD, w0(7'h20), 64'hDEAD, w0(7'h20), 64'hDEAD, w0(7'h40), 64'hDEAD, w0(7'h20)};
    b0 = wb_cnt;
    for (int i = 0; i < 8; i++) rd(addrs[i], hits[i], datas[i], lat);
    n_cmp++; if (wb_cnt - b0 !== 0) begin n_err++; $display("FAIL lru_wbs got=%0d want=0", wb_cnt - b0); end
  endtask

  task automatic test_reset_mid_fill();
    int guard = 0;
    int lat, f0;
    f0 = fill_cnt;
    while (!cpu_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h300;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin @(posedge clk); #1; guard++; end
    if (!mem_req) begin
      n_cmp++; n_err++; $display("FAIL midfill_no_req got=%b want=1", mem_req);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL midfill_mem_req got=%b want=0", mem_req); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL midfill_ready got=%b want=1", cpu_ready); end
    rst_n = 1'b1;
    n_cmp++; if (fill_cnt - f0 !== 0) begin n_err++; $display("FAIL midfill_fills got=%0d want=0", fill_cnt - f0); end
    rd(10'h300, 1'b0, w0(7'h60), lat);
    rd(10'h000, 1'b0, 64'hDEAD, lat);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {w0(7'(i)), w1(7'(i))};
    mem[0] = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_wb();
    test_lru();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
